// File: rtl/rf_param.sv
// rf_param: parameterised register file for the ID stage.
//   DEPTH = 2**ADDR_W entries of DATA_W bits, NREAD asynchronous read ports,
//   optional hardwired zero register, same-cycle write-to-read forwarding,
//   a debug tap on one fixed entry, and a clear engine that zeroes every
//   entry after reset (Busy high while it runs).
// Ports:
//   clk        clock, all state on rising edge
//   Reset      synchronous active-high reset
//   ReadReg    NREAD packed read indices, port i at [i*ADDR_W +: ADDR_W]
//   ReadData   NREAD packed read data,    port i at [i*DATA_W +: DATA_W]
//   WriteReg   write index
//   WriteData  write data
//   RegWrite   write enable (ignored while Busy)
//   Busy       clear engine running
//   Tap        contents of entry TAP_IDX, same masking/forwarding as reads

// One read lane: zero-register mask, then forwarding, then array data.
module rf_param_rport #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 5,
  parameter int ZERO_EN   = 1,
  parameter int ZERO_IDX  = 31,
  parameter int BYPASS_EN = 1
) (
  input  logic              busy_i,
  input  logic [ADDR_W-1:0] ridx_i,
  input  logic [DATA_W-1:0] rarr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(ZERO_IDX);

  always_comb begin
    rdata_o = rarr_i;
    if (busy_i)
      rdata_o = '0;
    else if (ZERO_EN != 0 && ridx_i == ZIDX)
      rdata_o = '0;
    // A zero-register write never reaches here when ZERO_EN is set: the
    // reader of that index is already masked by the branch above.
    else if (BYPASS_EN != 0 && we_i && widx_i == ridx_i)
      rdata_o = wdata_i;
  end
endmodule

module rf_param #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 5,
  parameter int NREAD     = 2,
  parameter int ZERO_EN   = 1,
  parameter int ZERO_IDX  = 31,
  parameter int BYPASS_EN = 1,
  parameter int TAP_IDX   = 20
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic [NREAD*ADDR_W-1:0] ReadReg,
  output logic [NREAD*DATA_W-1:0] ReadData,
  input  logic [ADDR_W-1:0]       WriteReg,
  input  logic [DATA_W-1:0]       WriteData,
  input  logic                    RegWrite,
  output logic                    Busy,
  output logic [DATA_W-1:0]       Tap
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(ZERO_IDX);
  localparam logic [ADDR_W-1:0] TIDX = ADDR_W'(TAP_IDX);
  localparam logic [ADDR_W:0]   LAST = (ADDR_W+1)'(DEPTH-1);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;
  logic              fwd_we;

  assign Busy  = (state_q == S_CLEAR);
  assign wr_en = !Busy && RegWrite && !(ZERO_EN != 0 && WriteReg == ZIDX);
  assign fwd_we = !Busy && RegWrite;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) state_d = S_RUN;
    end
  end

  // Reset also zeroes entry 0 so that a held reset leaves the engine
  // consistent with having cleared index cnt=0 on every edge.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= S_CLEAR;
      cnt_q    <= '0;
      mem_q[0] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_CLEAR)
        mem_q[cnt_q[ADDR_W-1:0]] <= '0;
      else if (wr_en)
        mem_q[WriteReg] <= WriteData;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    rf_param_rport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_EN(ZERO_EN),
      .ZERO_IDX(ZERO_IDX), .BYPASS_EN(BYPASS_EN)
    ) u_rp (
      .busy_i (Busy),
      .ridx_i (ReadReg[g*ADDR_W +: ADDR_W]),
      .rarr_i (mem_q[ReadReg[g*ADDR_W +: ADDR_W]]),
      .we_i   (fwd_we),
      .widx_i (WriteReg),
      .wdata_i(WriteData),
      .rdata_o(ReadData[g*DATA_W +: DATA_W])
    );
  end

  rf_param_rport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_EN(ZERO_EN),
    .ZERO_IDX(ZERO_IDX), .BYPASS_EN(BYPASS_EN)
  ) u_tap (
    .busy_i (Busy),
    .ridx_i (TIDX),
    .rarr_i (mem_q[TIDX]),
    .we_i   (fwd_we),
    .widx_i (WriteReg),
    .wdata_i(WriteData),
    .rdata_o(Tap)
  );
endmodule

// File: tb/tb_rf_param.sv
module tb_rf_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic Reset = 1'b1;

  // 64-bit group: a = defaults with 3 ports; b = no bypass, no zero reg, tap 31
  logic [14:0]  rr_a = '0;
  logic [191:0] rd_a;
  logic [4:0]   rr_b = '0;
  logic [63:0]  rd_b;
  logic [4:0]   wa64 = '0;
  logic [63:0]  wd64 = '0;
  logic         we64 = 1'b0;
  logic         busy_a, busy_b;
  logic [63:0]  tap_a, tap_b;

  // 32-bit / 16-entry group: c = zero reg 15, tap 15; d = no zero reg, tap 15
  logic [7:0]   rr32 = '0;
  logic [63:0]  rd_c, rd_d;
  logic [3:0]   wa32 = '0;
  logic [31:0]  wd32 = '0;
  logic         we32 = 1'b0;
  logic         busy_c, busy_d;
  logic [31:0]  tap_c, tap_d;

  rf_param #(.NREAD(3)) u_a (
    .clk(clk), .Reset(Reset), .ReadReg(rr_a), .ReadData(rd_a), .WriteReg(wa64),
    .WriteData(wd64), .RegWrite(we64), .Busy(busy_a), .Tap(tap_a));

  rf_param #(.NREAD(1), .ZERO_EN(0), .BYPASS_EN(0), .TAP_IDX(31)) u_b (
    .clk(clk), .Reset(Reset), .ReadReg(rr_b), .ReadData(rd_b), .WriteReg(wa64),
    .WriteData(wd64), .RegWrite(we64), .Busy(busy_b), .Tap(tap_b));

  rf_param #(.DATA_W(32), .ADDR_W(4), .ZERO_IDX(15), .TAP_IDX(15)) u_c (
    .clk(clk), .Reset(Reset), .ReadReg(rr32), .ReadData(rd_c), .WriteReg(wa32),
    .WriteData(wd32), .RegWrite(we32), .Busy(busy_c), .Tap(tap_c));

  rf_param #(.DATA_W(32), .ADDR_W(4), .ZERO_EN(0), .TAP_IDX(15)) u_d (
    .clk(clk), .Reset(Reset), .ReadReg(rr32), .ReadData(rd_d), .WriteReg(wa32),
    .WriteData(wd32), .RegWrite(we32), .Busy(busy_d), .Tap(tap_d));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs edges with Reset low until each instance leaves Busy; returns the
  // edge count per instance (-1 if it never dropped within the bound).
  task automatic run_clear(output int ka, output int kb, output int kc, output int kd);
    ka = -1; kb = -1; kc = -1; kd = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 5) begin
        chk("clear_read_forced0", rd_a[63:0], 64'd0);
        chk("clear_tap_forced0", tap_a, 64'd0);
      end
      if (!busy_a && ka < 0) begin ka = k; we64 = 1'b0; end
      if (!busy_b && kb < 0) kb = k;
      if (!busy_c && kc < 0) kc = k;
      if (!busy_d && kd < 0) kd = k;
      if (ka > 0 && kb > 0 && kc > 0 && kd > 0) break;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rr_a = {5'(i), 5'(31 - i), 5'(i)};
      rr_b = 5'(i);
      #1;
      chk({tag, "_a"}, {63'd0, |rd_a}, 64'd0);
      chk({tag, "_b"}, rd_b, 64'd0);
      if (i < 16) begin
        rr32 = {4'(i), 4'(15 - i)};
        #1;
        chk({tag, "_c"}, rd_c, 64'd0);
        chk({tag, "_d"}, rd_d, 64'd0);
      end
    end
    chk({tag, "_tap_a"}, tap_a, 64'd0);
    chk({tag, "_tap_b"}, tap_b, 64'd0);
    chk({tag, "_tap_d"}, {32'd0, tap_d}, 64'd0);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  r0, r1, r2;
    logic [63:0] e0, e1, e2, et, eb, ebt;
  } vec_t;

  localparam logic [63:0] CV = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ON = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    vec_t tv[9];
    int ka, kb, kc, kd;

    // Expected values are the pre-edge (combinational) view of each vector.
    tv[0] = '{1'b1, 5'd7,  CV,       5'd7,  5'd7,  5'd0,  CV,    CV,    64'd0, 64'd0,   64'd0,   64'd0};
    tv[1] = '{1'b0, 5'd0,  64'd0,    5'd7,  5'd0,  5'd7,  CV,    64'd0, CV,    64'd0,   CV,      64'd0};
    tv[2] = '{1'b1, 5'd31, ON,       5'd31, 5'd31, 5'd31, 64'd0, 64'd0, 64'd0, 64'd0,   64'd0,   64'd0};
    tv[3] = '{1'b0, 5'd0,  64'd0,    5'd31, 5'd31, 5'd7,  64'd0, 64'd0, CV,    64'd0,   ON,      ON};
    tv[4] = '{1'b1, 5'd20, 64'h55,   5'd20, 5'd20, 5'd3,  64'h55, 64'h55, 64'd0, 64'h55, 64'd0,   ON};
    tv[5] = '{1'b0, 5'd0,  64'd0,    5'd20, 5'd20, 5'd3,  64'h55, 64'h55, 64'd0, 64'h55, 64'h55,  ON};
    tv[6] = '{1'b1, 5'd3,  64'hA5A5, 5'd3,  5'd20, 5'd5,  64'hA5A5, 64'h55, 64'd0, 64'h55, 64'd0, ON};
    tv[7] = '{1'b1, 5'd20, 64'h99,   5'd20, 5'd3,  5'd31, 64'h99, 64'hA5A5, 64'd0, 64'h99, 64'h55, ON};
    tv[8] = '{1'b0, 5'd0,  64'd0,    5'd20, 5'd7,  5'd0,  64'h99, CV,    64'd0, 64'h99,  64'h99,  ON};

    // Reset 3 cycles with a write to X5 pending the whole time.
    Reset = 1'b1; we64 = 1'b1; wa64 = 5'd5; wd64 = 64'hDEAD; rr_a = {5'd5, 5'd5, 5'd5};
    tick();
    chk("reset_busy_a", {63'd0, busy_a}, 64'd1);
    chk("reset_busy_c", {63'd0, busy_c}, 64'd1);
    tick(); tick();
    Reset = 1'b0;
    run_clear(ka, kb, kc, kd);
    chk("clear_edges_a", 64'(ka), 64'd32);
    chk("clear_edges_b", 64'(kb), 64'd32);
    chk("clear_edges_c", 64'(kc), 64'd16);
    chk("clear_edges_d", 64'(kd), 64'd16);
    check_all_zero("after_clear");

    // Table-driven RUN-mode vectors on the 64-bit group.
    for (int i = 0; i < 9; i++) begin
      we64 = tv[i].we; wa64 = tv[i].wa; wd64 = tv[i].wd;
      rr_a = {tv[i].r2, tv[i].r1, tv[i].r0};
      rr_b = tv[i].r0;
      #1;
      chk($sformatf("v%0d_lane0", i), rd_a[63:0],    tv[i].e0);
      chk($sformatf("v%0d_lane1", i), rd_a[127:64],  tv[i].e1);
      chk($sformatf("v%0d_lane2", i), rd_a[191:128], tv[i].e2);
      chk($sformatf("v%0d_tap",   i), tap_a,         tv[i].et);
      chk($sformatf("v%0d_b",     i), rd_b,          tv[i].eb);
      chk($sformatf("v%0d_btap",  i), tap_b,         tv[i].ebt);
      tick();
    end
    we64 = 1'b0;

    // 32-bit / 16-entry sweep: X15 all-ones.
    wa32 = 4'd15; wd32 = 32'hFFFF_FFFF; we32 = 1'b1; rr32 = {4'd15, 4'd15};
    #1;
    chk("w15_pre_c", rd_c, 64'd0);
    chk("w15_pre_ctap", {32'd0, tap_c}, 64'd0);
    chk("w15_pre_d", rd_d, ON);
    chk("w15_pre_dtap", {32'd0, tap_d}, 64'hFFFF_FFFF);
    tick();
    we32 = 1'b0;
    #1;
    chk("w15_post_c", rd_c, 64'd0);
    chk("w15_post_d", rd_d, ON);
    chk("w15_post_dtap", {32'd0, tap_d}, 64'hFFFF_FFFF);
    wa32 = 4'd14; wd32 = 32'h1234; we32 = 1'b1; rr32 = {4'd15, 4'd14};
    #1;
    chk("w14_pre_c", rd_c, 64'h0000_0000_0000_1234);
    chk("w14_pre_d", rd_d, 64'hFFFF_FFFF_0000_1234);
    tick();
    we32 = 1'b0;
    #1;
    chk("w14_post_c", rd_c, 64'h0000_0000_0000_1234);

    // Reset pulse 10 edges into a clear: counter restarts from 0.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("mid_busy_a", {63'd0, busy_a}, 64'd1);
    Reset = 1'b1;
    tick();
    chk("mid_reset_busy", {63'd0, busy_a}, 64'd1);
    Reset = 1'b0;
    run_clear(ka, kb, kc, kd);
    chk("mid_edges_a", 64'(ka), 64'd32);
    chk("mid_edges_b", 64'(kb), 64'd32);
    chk("mid_edges_c", 64'(kc), 64'd16);
    chk("mid_edges_d", 64'(kd), 64'd16);
    check_all_zero("after_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
